cd_rx_fetch: RTL and testbench



---
 rtl/cd_rx_fetch.sv | 220 ++++++++++++++++++++++
 tb/tb_cd_rx_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_rx_fetch.sv
// cd_rx_fetch: autonomous CSR-bus master that drains received CDBUS frames.
// Polls INT_FLAG, clears RX error/lost flags, rewinds the RX read pointer,
// streams header (src, dst, len) plus payload over valid/ready, then
// releases the RX page. A frame whose length byte exceeds MAX_LEN is
// dropped after its two address bytes have been streamed.
module cd_rx_fetch #(
    parameter int unsigned POLL_DIV = 1000,
    parameter int unsigned MAX_LEN  = 253
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       irq,
    output logic [4:0] csr_address,
    output logic       csr_read,
    output logic       csr_write,
    output logic [7:0] csr_writedata,
    input  logic [7:0] csr_readdata,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [4:0]  ADDR_INT_FLAG  = 5'h10;
    localparam logic [4:0]  ADDR_RX        = 5'h14;
    localparam logic [4:0]  ADDR_RX_CTRL   = 5'h16;
    localparam logic [7:0]  CTRL_RST_PTR   = 8'h01;
    localparam logic [7:0]  CTRL_PAGE_DONE = 8'h02;
    localparam logic [7:0]  CTRL_CLR_FLAGS = 8'h0C;
    localparam logic [15:0] POLL_RELOAD    = 16'(POLL_DIV - 1);
    localparam logic [7:0]  MAX_LEN_B      = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_CLR,
        S_RST,
        S_RD,
        S_DRAIN,
        S_DONE,
        S_DISC
    } state_t;

    state_t      state;
    logic [15:0] poll_cnt;
    logic        poll_rd;    // INT_FLAG read strobe, high for the whole POLL cycle
    logic        pend_q;     // rx_pending captured during POLL
    logic        in_hdr;     // still reading src/dst/len
    logic [7:0]  rem;        // bytes left: header bytes first, then payload
    logic        poll_go;
    logic        out_free;
    logic        rd_fire;
    logic [8:0]  err_sum;

    // The output register can take a new byte when empty or being emptied now.
    assign out_free = !m_valid || m_ready;
    // RX reads are gated by the consumer in the same cycle, so this strobe is
    // decoded from state and m_ready to sustain one byte per clock.
    assign rd_fire  = (state == S_RD) && out_free;
    assign csr_read = poll_rd | rd_fire;
    assign poll_go  = enable && ((poll_cnt == 16'd0) || irq);
    assign busy     = (state != S_IDLE);

    // Error counter plus the lost/error bits of the INT_FLAG value being read.
    always_comb begin
        err_sum = {1'b0, err_cnt} + 9'(csr_readdata[2]) + 9'(csr_readdata[3]);
    end

    // Fetch sequencer: CSR accesses, stream output register and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            poll_cnt      <= POLL_RELOAD;
            poll_rd       <= 1'b0;
            pend_q        <= 1'b0;
            in_hdr        <= 1'b0;
            rem           <= 8'd0;
            csr_address   <= 5'd0;
            csr_write     <= 1'b0;
            csr_writedata <= 8'd0;
            m_data        <= 8'd0;
            m_valid       <= 1'b0;
            m_last        <= 1'b0;
            frame_cnt     <= 8'd0;
            err_cnt       <= 8'd0;
        end else begin
            // Every access is a single-cycle strobe.
            csr_write <= 1'b0;
            poll_rd   <= 1'b0;
            // A handshake empties the output register unless RD refills it.
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (poll_go) begin
                        state       <= S_POLL;
                        poll_rd     <= 1'b1;
                        csr_address <= ADDR_INT_FLAG;
                        poll_cnt    <= POLL_RELOAD;
                    end else if (poll_cnt != 16'd0) begin
                        poll_cnt <= poll_cnt - 16'd1;
                    end
                end

                S_POLL: begin
                    // The POLL cycle counts toward the interval, so idle
                    // polls are POLL_DIV cycles apart.
                    if (poll_cnt != 16'd0) poll_cnt <= poll_cnt - 16'd1;
                    pend_q <= csr_readdata[1];
                    if (csr_readdata[2] || csr_readdata[3]) begin
                        err_cnt       <= err_sum[8] ? 8'hFF : err_sum[7:0];
                        csr_write     <= 1'b1;
                        csr_address   <= ADDR_RX_CTRL;
                        csr_writedata <= CTRL_CLR_FLAGS;
                        state         <= S_CLR;
                    end else if (csr_readdata[1]) begin
                        csr_write     <= 1'b1;
                        csr_address   <= ADDR_RX_CTRL;
                        csr_writedata <= CTRL_RST_PTR;
                        state         <= S_RST;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_CLR: begin
                    if (pend_q) begin
                        csr_write     <= 1'b1;
                        csr_address   <= ADDR_RX_CTRL;
                        csr_writedata <= CTRL_RST_PTR;
                        state         <= S_RST;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_RST: begin
                    // Always rewind first so an interrupted page is re-read whole.
                    rem         <= 8'd3;
                    in_hdr      <= 1'b1;
                    csr_address <= ADDR_RX;
                    state       <= S_RD;
                end

                S_RD: begin
                    if (rd_fire) begin
                        if (in_hdr && (rem == 8'd1)) begin
                            // Length byte decides between streaming and discard.
                            if (csr_readdata > MAX_LEN_B) begin
                                m_valid       <= 1'b0;
                                m_last        <= 1'b0;
                                err_cnt       <= (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
                                csr_write     <= 1'b1;
                                csr_address   <= ADDR_RX_CTRL;
                                csr_writedata <= CTRL_PAGE_DONE;
                                state         <= S_DISC;
                            end else begin
                                m_data  <= csr_readdata;
                                m_valid <= 1'b1;
                                m_last  <= (csr_readdata == 8'd0);
                                rem     <= csr_readdata;
                                in_hdr  <= 1'b0;
                                if (csr_readdata == 8'd0) state <= S_DRAIN;
                            end
                        end else begin
                            m_data  <= csr_readdata;
                            m_valid <= 1'b1;
                            rem     <= rem - 8'd1;
                            if (!in_hdr && (rem == 8'd1)) begin
                                m_last <= 1'b1;
                                state  <= S_DRAIN;
                            end else begin
                                m_last <= 1'b0;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    // Release the page only once the last byte has been taken.
                    if (out_free) begin
                        frame_cnt     <= frame_cnt + 8'd1;
                        csr_write     <= 1'b1;
                        csr_address   <= ADDR_RX_CTRL;
                        csr_writedata <= CTRL_PAGE_DONE;
                        state         <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Check straight away for a further pending frame.
                    if (enable) begin
                        state       <= S_POLL;
                        poll_rd     <= 1'b1;
                        csr_address <= ADDR_INT_FLAG;
                        poll_cnt    <= POLL_RELOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_DISC: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cd_rx_fetch.sv
// Bench for cd_rx_fetch: a small CDBUS controller model answers the CSR
// port, expected stream bytes and RX_CTRL writes go to scoreboard queues
// when a frame is loaded and are checked as the DUT produces them.
module tb_cd_rx_fetch;

    localparam int POLL_DIV = 4;
    localparam int MAX_LEN  = 253;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       irq = 1'b0;
    logic       m_ready = 1'b0;
    logic [4:0] csr_address;
    logic       csr_read;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic [7:0] csr_readdata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       busy;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    cd_rx_fetch #(.POLL_DIV(POLL_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    // ---------------- controller model ----------------
    logic [7:0] flags = 8'h00;
    logic [7:0] mem [0:271];
    int         rd_ptr = 0;
    int         rd14 = 0;
    int         cyc = 0;
    logic       load_req = 1'b0;
    logic [7:0] load_val = 8'h00;
    int         poll_q [$];

    assign csr_readdata = (csr_address == 5'h10) ? flags :
                          ((csr_address == 5'h14) && (rd_ptr < 272)) ? mem[rd_ptr] : 8'h00;

    function automatic logic [7:0] next_flags(input logic ld, input logic [7:0] ldv,
                                              input logic [7:0] cur, input logic wr,
                                              input logic [7:0] wd);
        logic [7:0] f;
        f = ld ? ldv : cur;
        if (wr) f = f & ~{4'b0000, wd[3:1], 1'b0};
        return f;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        flags <= next_flags(load_req, load_val, flags,
                            csr_write && (csr_address == 5'h16), csr_writedata);
        if (csr_read && (csr_address == 5'h10)) poll_q.push_back(cyc);
        if (csr_read && (csr_address == 5'h14)) begin
            rd_ptr <= rd_ptr + 1;
            rd14   <= rd14 + 1;
        end else if (csr_write && (csr_address == 5'h16) && csr_writedata[0]) begin
            rd_ptr <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    logic [8:0]  exp_q [$];    // {last, data}
    logic [12:0] wexp_q [$];   // {address, writedata}
    logic        stall = 1'b0;
    int          exp_frames = 0;
    int          exp_err = 0;
    int          rd_base = 0;
    int          rd_exp = 0;

    typedef struct {
        logic [7:0] flags;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] len;
        logic [7:0] pay;
        logic       stall;
        int         frm_inc;
        int         err_inc;
    } case_t;

    case_t cases [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready: always 1, or the pattern 1,0,0,1 when stalling.
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall) begin
                m_ready = pat[k % 4];
                k++;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    initial begin
        logic       hold;
        logic [8:0] held;
        logic [8:0] e;
        logic [12:0] w;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (csr_read && csr_write) begin
                    total++; bad++;
                    $display("FAIL strobe_overlap: read and write both high at cycle %0d", cyc);
                end
                if (hold) begin
                    total++;
                    if ({m_valid, m_last, m_data} !== {1'b1, held}) begin
                        bad++;
                        $display("FAIL hold_stable: got %0h expected %0h", {m_valid, m_last, m_data}, {1'b1, held});
                    end
                end
                if (csr_read && (csr_address == 5'h14)) begin
                    total++;
                    if (m_valid && !m_ready) begin
                        bad++;
                        $display("FAIL stall_read: RX read while byte %0h unaccepted", m_data);
                    end
                end
                if (m_valid && m_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_byte: got %0h expected none", {m_last, m_data});
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_last, m_data} !== e) begin
                            bad++;
                            $display("FAIL stream_byte: got last/data %0h expected %0h", {m_last, m_data}, e);
                        end
                    end
                    pops++;
                end
                if (csr_write) begin
                    total++;
                    if (wexp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_write: got %0h/%0h expected none", csr_address, csr_writedata);
                    end else begin
                        w = wexp_q.pop_front();
                        if ({csr_address, csr_writedata} !== w) begin
                            bad++;
                            $display("FAIL csr_write: got %0h expected %0h", {csr_address, csr_writedata}, w);
                        end
                    end
                end
                hold = m_valid && !m_ready;
                held = {m_last, m_data};
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Load a frame into the model and queue everything the DUT should do with it.
    task automatic prep_case(input case_t c);
        mem[0] = c.src;
        mem[1] = c.dst;
        mem[2] = c.len;
        for (int i = 0; i < int'(c.len); i++) mem[3 + i] = 8'(int'(c.pay) + i * 17);
        stall  = c.stall;
        rd_exp = 0;
        if (c.flags[2] || c.flags[3]) wexp_q.push_back({5'h16, 8'h0C});
        if (c.flags[1]) begin
            wexp_q.push_back({5'h16, 8'h01});
            exp_q.push_back({1'b0, c.src});
            exp_q.push_back({1'b0, c.dst});
            if (int'(c.len) > MAX_LEN) begin
                rd_exp = 3;
            end else begin
                exp_q.push_back({(c.len == 8'd0), c.len});
                for (int i = 0; i < int'(c.len); i++)
                    exp_q.push_back({(i == int'(c.len) - 1), 8'(int'(c.pay) + i * 17)});
                rd_exp = 3 + int'(c.len);
            end
            wexp_q.push_back({5'h16, 8'h02});
        end
        exp_frames = (exp_frames + c.frm_inc) % 256;
        exp_err    = (exp_err + c.err_inc > 255) ? 255 : exp_err + c.err_inc;
        rd_base    = rd14;
        load_val   = c.flags;
        load_req   = 1'b1;
        @(posedge clk);
        #1;
        load_req   = 1'b0;
    endtask

    // Wait for the controller to be drained and the DUT quiet, then check counters.
    task automatic finish_case(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((flags == 8'h00) && (exp_q.size() == 0) && (wexp_q.size() == 0) && !busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout: flags=%0h bytes_left=%0d writes_left=%0d", name, flags, exp_q.size(), wexp_q.size());
        end
        repeat (6) @(posedge clk);
        #1;
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        check({name, "_rx_reads"}, 64'(rd14 - rd_base), 64'(rd_exp));
    endtask

    task automatic wait_pops(input int n);
        for (int i = 0; i < 400 && pops < n; i++) begin
            @(posedge clk);
            #1;
        end
        check("pop_wait", 64'(pops >= n), 64'd1);
    endtask

    task automatic wait_poll(input int n0);
        for (int i = 0; i < 50 && poll_q.size() <= n0; i++) begin
            @(posedge clk);
            #1;
        end
        check("poll_wait", 64'(poll_q.size() > n0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int c0;
        case_t c;

        cases[0] = '{8'h02, 8'h01, 8'h02, 8'd2,   8'hAA, 1'b0, 1, 0};
        cases[1] = '{8'h02, 8'h01, 8'h02, 8'd2,   8'hAA, 1'b1, 1, 0};
        cases[2] = '{8'h0E, 8'h10, 8'h20, 8'd3,   8'h30, 1'b0, 1, 2};
        cases[3] = '{8'h02, 8'h40, 8'h41, 8'hFE,  8'h00, 1'b0, 0, 1};
        cases[4] = '{8'h02, 8'h50, 8'h51, 8'd0,   8'h00, 1'b1, 1, 0};
        cases[5] = '{8'h08, 8'h58, 8'h59, 8'd2,   8'h00, 1'b0, 0, 1};
        cases[6] = '{8'h02, 8'h60, 8'h61, 8'd253, 8'h01, 1'b1, 1, 0};
        cases[7] = '{8'h06, 8'h70, 8'h71, 8'd1,   8'h05, 1'b0, 1, 1};
        for (int i = 0; i < 272; i++) mem[i] = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state",
              64'({csr_address, csr_read, csr_write, csr_writedata, m_data, m_valid, m_last, busy, frame_cnt, err_cnt}),
              64'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Idle polling: INT_FLAG read every POLL_DIV cycles.
        n0 = poll_q.size();
        wait_poll(n0 + 2);
        if (poll_q.size() >= n0 + 3) begin
            check("poll_period_a", 64'(poll_q[n0 + 1] - poll_q[n0]), 64'd4);
            check("poll_period_b", 64'(poll_q[n0 + 2] - poll_q[n0 + 1]), 64'd4);
        end

        // irq forces a poll on the next cycle.
        n0 = poll_q.size();
        wait_poll(n0);
        c0 = poll_q[poll_q.size() - 1];
        n0 = poll_q.size();
        irq = 1'b1;
        @(posedge clk);
        #1;
        irq = 1'b0;
        wait_poll(n0);
        if (poll_q.size() > n0) check("irq_poll", 64'(poll_q[n0] - c0), 64'd2);

        // Table of frames.
        for (int i = 0; i < 8; i++) begin
            prep_case(cases[i]);
            finish_case($sformatf("case%0d", i));
        end

        // Dropping enable mid-frame completes the frame, then polling stops.
        c = '{8'h02, 8'h90, 8'h91, 8'd3, 8'h20, 1'b1, 1, 0};
        prep_case(c);
        wait_pops(pops + 1);
        enable = 1'b0;
        finish_case("disable");
        n0 = poll_q.size();
        repeat (20) @(posedge clk);
        #1;
        check("no_poll_disabled", 64'(poll_q.size()), 64'(n0));
        check("idle_disabled", 64'(busy), 64'd0);

        // Reset after two streamed bytes: page is re-read from src.
        enable = 1'b1;
        c = '{8'h02, 8'h81, 8'h82, 8'd4, 8'h40, 1'b0, 1, 0};
        prep_case(c);
        wait_pops(pops + 2);
        reset_n = 1'b0;
        #1;
        check("reset_mid_frame",
              64'({csr_address, csr_read, csr_write, csr_writedata, m_data, m_valid, m_last, busy, frame_cnt, err_cnt}),
              64'd0);
        exp_q.delete();
        wexp_q.delete();
        exp_frames = 1;
        exp_err    = 0;
        wexp_q.push_back({5'h16, 8'h01});
        exp_q.push_back({1'b0, 8'h81});
        exp_q.push_back({1'b0, 8'h82});
        exp_q.push_back({1'b0, 8'h04});
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 8'(8'h40 + i * 17)});
        wexp_q.push_back({5'h16, 8'h02});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd_base = rd14;
        rd_exp  = 7;
        finish_case("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
